// File: rtl/dbg_pkg.sv
// Shared constants, state types and helpers for the hex probe panel:
// 7-segment encoding and page-geometry arithmetic.
package dbg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Debouncer states; ST_ARM waits for a confirmed release after reset.
    typedef enum logic [1:0] {
        ST_ARM      = 2'd0,
        ST_RELEASED = 2'd1,
        ST_PRESSED  = 2'd2
    } db_state_e;

    // Active-low segment pattern, bit order gfedcba.
    function automatic logic [6:0] hex2seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

    function automatic int unsigned pages_per_ch(input int unsigned data_w,
                                                 input int unsigned num_digits);
        return ceil_div(data_w, 4 * num_digits);
    endfunction

    function automatic int unsigned num_pages(input int unsigned num_ch,
                                              input int unsigned data_w,
                                              input int unsigned num_digits);
        return num_ch * pages_per_ch(data_w, num_digits);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw active-low button debouncer: two-flop synchroniser, stability counter,
// one-cycle press pulse on each accepted press.
module btn_debounce
    import dbg_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic CLK,
    input  logic RST,
    input  logic btn_n,
    output logic press_o
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             btn_s;
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    assign btn_s = sync_q[1];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q  <= 2'b11;
            state_q <= ST_ARM;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_n};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    // Counter runs only while the synchronised level differs from the accepted one;
    // any return to the accepted level clears it.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        press_d = 1'b0;
        case (state_q)
            ST_ARM: begin
                if (btn_s) begin
                    if (cnt_q == CNT_LAST) state_d = ST_RELEASED;
                    else                   cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_RELEASED: begin
                if (!btn_s) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_PRESSED;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_PRESSED: begin
                if (btn_s) begin
                    if (cnt_q == CNT_LAST) state_d = ST_RELEASED;
                    else                   cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_ARM;
        endcase
    end

    assign press_o = press_q;

endmodule

// File: rtl/hex_probe_panel.sv
// Board debug front-end: snapshots CPU probe words and pages their nibbles
// onto a bank of active-low 7-segment digits under button control.
module hex_probe_panel
    import dbg_pkg::*;
#(
    parameter  int unsigned NUM_CH          = 4,
    parameter  int unsigned DATA_W          = 32,
    parameter  int unsigned NUM_DIGITS      = 6,
    parameter  int unsigned DEBOUNCE_CYCLES = 500000,
    localparam int unsigned NUM_PAGES       = num_pages(NUM_CH, DATA_W, NUM_DIGITS),
    localparam int unsigned PAGE_W          = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [NUM_CH*DATA_W-1:0]   probe_i,
    input  logic                       capture_i,
    input  logic                       freeze_i,
    input  logic                       btn_up_n,
    input  logic                       btn_dn_n,
    output logic [NUM_DIGITS*7-1:0]    nhex_o,
    output logic [PAGE_W-1:0]          page_o,
    output logic                       frozen_o
);

    localparam int unsigned PPC     = pages_per_ch(DATA_W, NUM_DIGITS);
    localparam int unsigned PAD_W   = PPC * NUM_DIGITS * 4;
    localparam int unsigned PROBE_W = NUM_CH * DATA_W;
    localparam int unsigned NHEX_W  = NUM_DIGITS * 7;
    localparam logic [PAGE_W-1:0] PAGE_LAST = PAGE_W'(NUM_PAGES - 1);

    // Display of page 0 with all-zero shadows.
    function automatic logic [NHEX_W-1:0] reset_pattern();
        logic [NHEX_W-1:0] r;
        r = '1;
        for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
            r[d*7 +: 7] = (d * 4 < DATA_W) ? hex2seg(4'h0) : SEG_BLANK;
        end
        return r;
    endfunction

    localparam logic [NHEX_W-1:0] NHEX_RST = reset_pattern();

    logic                up_press, dn_press;
    logic [PROBE_W-1:0]  shadow_q, shadow_d;
    logic [PAGE_W-1:0]   page_q, page_d;
    logic                frozen_q;
    logic [NHEX_W-1:0]   nhex_q, nhex_d;

    int unsigned         sel_ch, sel_slice, nib_idx;
    logic [DATA_W-1:0]   sel_word;
    logic [PAD_W-1:0]    sel_pad;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .CLK     (CLK),
        .RST     (RST),
        .btn_n   (btn_up_n),
        .press_o (up_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dn (
        .CLK     (CLK),
        .RST     (RST),
        .btn_n   (btn_dn_n),
        .press_o (dn_press)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shadow_q <= '0;
            page_q   <= '0;
            frozen_q <= 1'b0;
            nhex_q   <= NHEX_RST;
        end else begin
            shadow_q <= shadow_d;
            page_q   <= page_d;
            frozen_q <= freeze_i;
            nhex_q   <= nhex_d;
        end
    end

    // Snapshot: all channels load together unless frozen.
    always_comb begin
        shadow_d = shadow_q;
        if (capture_i && !freeze_i) shadow_d = probe_i;
    end

    // Wrapping page counter; simultaneous up and down cancel.
    always_comb begin
        page_d = page_q;
        if (up_press && !dn_press) begin
            page_d = (page_q == PAGE_LAST) ? '0 : page_q + PAGE_W'(1);
        end else if (dn_press && !up_press) begin
            page_d = (page_q == '0) ? PAGE_LAST : page_q - PAGE_W'(1);
        end
    end

    // Nibble select with zero padding above DATA_W; nibbles wholly past the word blank out.
    always_comb begin
        sel_ch    = 32'(page_q) / PPC;
        sel_slice = 32'(page_q) % PPC;
        sel_word  = shadow_q[sel_ch*DATA_W +: DATA_W];
        sel_pad   = PAD_W'(sel_word);
        nib_idx   = 0;
        nhex_d    = '1;
        for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
            nib_idx = sel_slice * NUM_DIGITS + d;
            if (nib_idx * 4 >= DATA_W) nhex_d[d*7 +: 7] = SEG_BLANK;
            else                       nhex_d[d*7 +: 7] = hex2seg(sel_pad[nib_idx*4 +: 4]);
        end
    end

    assign nhex_o   = nhex_q;
    assign page_o   = page_q;
    assign frozen_o = frozen_q;

endmodule

// File: tb/tb_hex_probe_panel.sv
// Scoreboarded bench for hex_probe_panel: a wide (4x32, 6 digits) and an
// odd-width (2x10, 2 digits) instance checked against a nibble-level model.
module tb_hex_probe_panel;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    logic [127:0] probe_a;
    logic [19:0]  probe_b;
    logic [1:0]   cap, frz, up_n, dn_n;

    logic [41:0]  nhex_a;
    logic [2:0]   page_a;
    logic         frozen_a;
    logic [13:0]  nhex_b;
    logic [1:0]   page_b;
    logic         frozen_b;

    hex_probe_panel #(.NUM_CH(4), .DATA_W(32), .NUM_DIGITS(6), .DEBOUNCE_CYCLES(4)) dut_a (
        .CLK(CLK), .RST(RST), .probe_i(probe_a), .capture_i(cap[0]), .freeze_i(frz[0]),
        .btn_up_n(up_n[0]), .btn_dn_n(dn_n[0]),
        .nhex_o(nhex_a), .page_o(page_a), .frozen_o(frozen_a)
    );

    hex_probe_panel #(.NUM_CH(2), .DATA_W(10), .NUM_DIGITS(2), .DEBOUNCE_CYCLES(4)) dut_b (
        .CLK(CLK), .RST(RST), .probe_i(probe_b), .capture_i(cap[1]), .freeze_i(frz[1]),
        .btn_up_n(up_n[1]), .btn_dn_n(dn_n[1]),
        .nhex_o(nhex_b), .page_o(page_b), .frozen_o(frozen_b)
    );

    int checks = 0;
    int fails  = 0;

    // Reference model state
    int          mpage [2];
    logic [31:0] msh   [2][4];
    logic        mfrz  [2];

    // Scoreboard
    int          q_sel  [$];
    logic [41:0] q_nhex [$];
    int          q_page [$];
    logic        q_frz  [$];
    string       q_name [$];

    function automatic logic [6:0] seg(input int v);
        case (v)
            0:  return 7'b1000000;
            1:  return 7'b1111001;
            2:  return 7'b0100100;
            3:  return 7'b0110000;
            4:  return 7'b0011001;
            5:  return 7'b0010010;
            6:  return 7'b0000010;
            7:  return 7'b1111000;
            8:  return 7'b0000000;
            9:  return 7'b0010000;
            10: return 7'b0001000;
            11: return 7'b0000011;
            12: return 7'b1000110;
            13: return 7'b0100001;
            14: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    function automatic int nd_of(input int sel);  return (sel == 0) ? 6 : 2;  endfunction
    function automatic int dw_of(input int sel);  return (sel == 0) ? 32 : 10; endfunction
    function automatic int nch_of(input int sel); return (sel == 0) ? 4 : 2;  endfunction
    function automatic int ppc_of(input int sel);
        return (dw_of(sel) + 4 * nd_of(sel) - 1) / (4 * nd_of(sel));
    endfunction
    function automatic int np_of(input int sel); return nch_of(sel) * ppc_of(sel); endfunction

    function automatic logic [41:0] exp_nhex(input int sel);
        logic [41:0] r;
        logic [31:0] w;
        int ch, s, n;
        ch = mpage[sel] / ppc_of(sel);
        s  = mpage[sel] % ppc_of(sel);
        w  = msh[sel][ch];
        r  = '0;
        for (int d = 0; d < nd_of(sel); d++) begin
            n = s * nd_of(sel) + d;
            if (n * 4 >= dw_of(sel)) r[d*7 +: 7] = 7'b1111111;
            else                     r[d*7 +: 7] = seg(int'((w >> (4 * n)) & 32'hF));
        end
        return r;
    endfunction

    task automatic push(input int sel, input string name);
        q_sel.push_back(sel);
        q_nhex.push_back(exp_nhex(sel));
        q_page.push_back(mpage[sel]);
        q_frz.push_back(mfrz[sel]);
        q_name.push_back(name);
    endtask

    // Monitor: one scoreboard entry is checked per falling edge.
    int          m_sel, m_ep, m_ap;
    logic [41:0] m_en, m_an;
    logic        m_ef, m_af;
    string       m_nm;
    always @(negedge CLK) begin
        if (q_sel.size() != 0) begin
            m_sel = q_sel.pop_front();
            m_en  = q_nhex.pop_front();
            m_ep  = q_page.pop_front();
            m_ef  = q_frz.pop_front();
            m_nm  = q_name.pop_front();
            m_an  = (m_sel == 0) ? nhex_a : {28'b0, nhex_b};
            m_ap  = (m_sel == 0) ? int'(page_a) : int'(page_b);
            m_af  = (m_sel == 0) ? frozen_a : frozen_b;
            checks++;
            if (m_an !== m_en) begin
                fails++;
                $display("FAIL %s nhex: got %h expected %h", m_nm, m_an, m_en);
            end
            checks++;
            if (m_ap != m_ep) begin
                fails++;
                $display("FAIL %s page: got %0d expected %0d", m_nm, m_ap, m_ep);
            end
            checks++;
            if (m_af !== m_ef) begin
                fails++;
                $display("FAIL %s frozen: got %b expected %b", m_nm, m_af, m_ef);
            end
        end
    end

    // Counts observed page changes on instance A.
    int         pg_chg = 0;
    logic [2:0] pg_prev = 3'd0;
    always @(negedge CLK) begin
        if (page_a !== pg_prev) pg_chg++;
        pg_prev = page_a;
    end

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            mpage[s] = 0;
            for (int c = 0; c < 4; c++) msh[s][c] = '0;
        end
    endtask

    // dir: 0 up, 1 down, 2 both together
    task automatic press(input int sel, input int dir);
        if (dir != 1) up_n[sel] = 1'b0;
        if (dir != 0) dn_n[sel] = 1'b0;
        cycles(12);
        up_n[sel] = 1'b1;
        dn_n[sel] = 1'b1;
        cycles(12);
        if (dir == 0)      mpage[sel] = (mpage[sel] + 1) % np_of(sel);
        else if (dir == 1) mpage[sel] = (mpage[sel] + np_of(sel) - 1) % np_of(sel);
    endtask

    task automatic set_freeze(input int sel, input logic v);
        frz[sel]  = v;
        mfrz[sel] = v;
        cycles(2);
    endtask

    // Checks the display is still old one cycle after the strobe and new the next.
    task automatic capture(input int sel, input logic [127:0] val, input string nm);
        if (sel == 0) probe_a = val;
        else          probe_b = val[19:0];
        cap[sel] = 1'b1;
        cycles(1);
        cap[sel] = 1'b0;
        push(sel, {nm, "_old"});
        if (!mfrz[sel]) begin
            for (int c = 0; c < nch_of(sel); c++)
                msh[sel][c] = (sel == 0) ? val[c*32 +: 32] : 32'(val[c*10 +: 10]);
        end
        cycles(1);
        push(sel, nm);
        cycles(2);
    endtask

    initial begin
        int base, sel, op;
        logic [127:0] rv;
        RST = 1'b1;
        probe_a = '0; probe_b = '0;
        cap = '0; frz = '0; up_n = '1; dn_n = '1;
        model_reset();
        mfrz[0] = 1'b0; mfrz[1] = 1'b0;

        cycles(3);
        push(0, "rst_hold_a");
        cycles(1);
        push(1, "rst_hold_b");
        cycles(1);
        RST = 1'b0;
        cycles(6);
        push(0, "rst_rel_a");
        cycles(1);
        push(1, "rst_rel_b");
        cycles(1);

        capture(0, 128'h89ABCDEF, "cap_89abcdef");
        press(0, 0);
        push(0, "page1_high_nibbles");
        press(0, 1);
        push(0, "dn_to_0");
        press(0, 1);
        push(0, "wrap_dn_to_7");
        press(0, 0);
        push(0, "wrap_up_to_0");
        for (int i = 0; i < 8; i++) press(0, 0);
        push(0, "eight_ups");
        press(0, 2);
        push(0, "both_buttons");

        base = pg_chg;
        for (int i = 0; i < 5; i++) begin
            up_n[0] = 1'b0; cycles(2);
            up_n[0] = 1'b1; cycles(2);
        end
        up_n[0] = 1'b0; cycles(10);
        up_n[0] = 1'b1; cycles(1);
        up_n[0] = 1'b0; cycles(1);
        up_n[0] = 1'b1; cycles(12);
        mpage[0] = (mpage[0] + 1) % np_of(0);
        check_int("bounce_single_pulse", pg_chg - base, 1);
        push(0, "bounce_page");

        set_freeze(0, 1'b1);
        capture(0, 128'h0000_0000_0000_0000_0000_0000_1234_5678, "frozen_capture");
        set_freeze(0, 1'b0);
        capture(0, 128'h0000_0000_0000_0000_0000_0000_1234_5678, "unfrozen_capture");

        capture(1, 128'h3FF, "b_cap_3ff");
        press(1, 0);
        push(1, "b_page1_partial");
        press(1, 0);
        push(1, "b_page2_ch1");

        // Reset mid-debounce with the button held through release.
        up_n[0] = 1'b0;
        cycles(3);
        RST = 1'b1;
        cycles(2);
        RST = 1'b0;
        model_reset();
        cycles(15);
        push(0, "held_through_reset");
        up_n[0] = 1'b1;
        cycles(12);
        push(0, "released_after_reset");
        press(0, 0);
        push(0, "press_after_reset");

        for (int it = 0; it < 24; it++) begin
            sel = int'($urandom_range(0, 1));
            op  = int'($urandom_range(0, 4));
            rv  = {$urandom, $urandom, $urandom, $urandom};
            case (op)
                0: capture(sel, rv, "rnd_cap");
                1: begin
                    set_freeze(sel, 1'($urandom_range(0, 1)));
                    capture(sel, rv, "rnd_frz_cap");
                end
                default: begin
                    press(sel, op - 2);
                    push(sel, "rnd_press");
                end
            endcase
        end

        cycles(4);
        checks++;
        if (q_sel.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q_sel.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/hex_probe_panel.md
# hex_probe_panel

Parametrised board debug front-end that pages any number of CPU probe words (PC, ALU result, control signals, and so on) onto a configurable bank of active-low 7-segment digits. It sits between the CPU core and the board HEX outputs, next to the manual-clock logic. Two debounced page buttons step through channels and nibble pages. A capture strobe plus a freeze switch make the displayed values a stable snapshot taken on each CPU step.

## Interface
Parameters:
- NUM_CH, 4, number of probe channels (≥1)
- DATA_W, 32, width of each probe word (≥1)
- NUM_DIGITS, 6, number of 7-segment digits driven (≥1)
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed to accept a button level (≥2)

Ports:
- CLK  in  1  system clock; the only clock.
- RST  in  1  reset, asynchronous, active-high.
- probe_i  in  NUM_CH*DATA_W  probe words; channel c occupies bits [c*DATA_W +: DATA_W].
- capture_i  in  1  single-cycle strobe, synchronous to CLK; loads the shadow registers.
- freeze_i  in  1  level; when high, shadow loads are blocked.
- btn_up_n  in  1  raw asynchronous button, active-low; next page.
- btn_dn_n  in  1  raw asynchronous button, active-low; previous page.
- nhex_o  out  NUM_DIGITS*7  segments, active-low; digit d occupies [d*7 +: 7], with digit 0 rightmost.
- page_o  out  $clog2(NUM_PAGES) (min 1)  current page index.
- frozen_o  out  1  registered copy of freeze_i.

## Operation
- PPC (pages per channel) = ceil(DATA_W / (4*NUM_DIGITS)). NUM_PAGES = NUM_CH*PPC.
- Page p maps to channel p / PPC and slice s = p % PPC.
- Digit d on page p shows nibble n = s*NUM_DIGITS + d of the channel's shadow word.
- Nibbles with n*4 ≥ DATA_W are blank (all segments off).
- A partial nibble (n*4 < DATA_W < n*4+4) is zero-extended.
- Shadow registers: NUM_CH × DATA_W.
  - When capture_i=1 and freeze_i=0, all channels load from probe_i together.
  - Otherwise they hold.
- Page counter:
  - up_pulse only: p → (p+1) mod NUM_PAGES.
  - dn_pulse only: p → (p−1) mod NUM_PAGES, so 0 wraps to NUM_PAGES−1.
  - Both pulses in the same cycle: no change.
- Debouncer, one per button:
  - Two-flop synchroniser feeds a stability counter.
  - The accepted level changes only after DEBOUNCE_CYCLES consecutive cycles of the new synchronised level.
  - Any bounce restarts the count.
  - A one-cycle pulse is emitted on each accepted high→low transition (press). Release produces no pulse.
- Segment encoding (active-low, bit order gfedcba): 0→1000000, 1→1111001, … F→0001110. Blank is 1111111.
- Reset values:
  - page = 0, all shadow registers = 0.
  - Debouncer accepted level = 1 (released), counters = 0, synchronisers = 1.
  - frozen_o = 0.
  - nhex_o: every digit that maps to a valid nibble = 1000000; any digit blank on page 0 = 1111111.
- RST asserted mid-debounce or mid-hold forces the reset values immediately. A button held through reset release does not produce a pulse until it is released and pressed again.

## Timing
- Press latency, from raw edge held stable to pulse: 2 synchroniser cycles + DEBOUNCE_CYCLES, ±1 cycle.
- page_o updates the cycle after the pulse.
- nhex_o is registered: it reflects a page or shadow change one cycle after that change, so capture to display is 2 cycles.
- capture_i and a page pulse in the same cycle are both applied.
- freeze_i is sampled in the cycle of capture_i. frozen_o lags freeze_i by one cycle.
- Throughput: one capture per cycle is accepted. Back-to-back capture strobes each reload the shadow registers.

## Structure
- dbg_pkg contains:
  - SEG_BLANK constant.
  - hex2seg function (4-bit value → 7-bit active-low pattern).
  - PPC/NUM_PAGES computation function, ceil-div.
- Sub-module btn_debounce (params DEBOUNCE_CYCLES; ports CLK, RST, btn_n, press_o). It is instantiated twice.
- The top of hex_probe_panel holds the shadow registers, the page counter, the nibble select and blanking mux, and the output register.

## Test plan
- Reset: NUM_CH=4, DATA_W=32, NUM_DIGITS=6, DEBOUNCE_CYCLES=4 → page_o=0 and nhex_o=6×1000000 while RST=1 and after release.
- Capture and paging: probe ch0=0x89ABCDEF, capture_i pulse. After 2 cycles, digits 5..0 = A,B,C,D,E,F. One up press → page 1 shows digits 1..0 = 8,9 and digits 5..2 blank.
- Wrap-around:
  - dn press from page 0 → page_o=7.
  - 8 up presses from page 0 → page_o=0.
  - Both buttons pulsed in the same cycle → page unchanged.
- Debounce: btn_up_n toggles every 2 cycles for 20 cycles, then held low 10 cycles → exactly one pulse and page +1. Release with 3-cycle bounce → no page change.
- Freeze: freeze_i=1, probe changes, capture_i pulsed → nhex_o unchanged and frozen_o=1. freeze_i=0 plus capture → new value shown 2 cycles later.
- Odd widths: DATA_W=10, NUM_DIGITS=2, probe=0x3FF → NUM_PAGES=2×NUM_CH. Page 0 shows F,F. Page 1 shows digit 0 = 3, digit 1 blank.
